// File: rtl/karatsuba_arbiter.sv
// karatsuba_arbiter: round-robin sharing of one external multiplier between N_REQ requesters
module karatsuba_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [2*DATA_W-1:0]     rsp_data,
  output logic [DATA_W-1:0]       mul_a,
  output logic [DATA_W-1:0]       mul_b,
  input  logic [2*DATA_W-1:0]     mul_p,
  output logic                    busy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MUL_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d, gnt_q, gnt_d, pick, idx;
  logic                found;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [2*DATA_W-1:0] rsp_data_q, rsp_data_d;
  // first valid requester after the last one served
  always_comb begin
    pick  = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = WAIT;
        gnt_d   = pick;
        cnt_d   = CW'(MUL_LAT);
        mul_a_d = req_a[int'(pick)*DATA_W +: DATA_W];
        mul_b_d = req_b[int'(pick)*DATA_W +: DATA_W];
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = RESP;
          rsp_data_d = mul_p;
        end
      end
      RESP: if (rsp_ready[gnt_q]) begin
        state_d = IDLE;
        ptr_d   = gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= IW'(N_REQ - 1);
      gnt_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  assign req_ready = (state_q == IDLE && found && !rst) ? (N_REQ'(1) << pick) : '0;
  assign rsp_valid = (state_q == RESP) ? (N_REQ'(1) << gnt_q) : '0;
  assign rsp_data  = rsp_data_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_karatsuba_arbiter.sv
// tb_karatsuba_arbiter: directed checks of karatsuba_arbiter with a pipelined multiplier model
module tb_karatsuba_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 3;
  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [2*W-1:0]   rsp_data, mul_p, p1, p2;
  logic [W-1:0]     mul_a, mul_b;
  logic             busy;
  int               n_chk = 0;
  int               n_fail = 0;
  int               last_wait;
  logic [2*W-1:0]   held;

  karatsuba_arbiter #(.N_REQ(N), .DATA_W(W), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
  );

  always #5 clk = ~clk;

  // multiplier stand-in: product valid L-1 edges after operands settle
  initial begin
    p1 = '0;
    p2 = '0;
  end
  always @(posedge clk) begin
    p1 <= 64'(mul_a) * 64'(mul_b);
    p2 <= p1;
  end
  assign mul_p = p2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic serve(input int idx, input logic [63:0] exp, input bit keep);
    last_wait = 0;
    #1;
    while (req_ready == '0 && last_wait < 20) begin
      tick;
      last_wait++;
    end
    chk("grant", 64'(req_ready), 64'(N'(1) << idx));
    tick;
    if (!keep) req_valid[idx] = 1'b0;
    chk("busy", 64'(busy), 64'd1);
    repeat (L - 1) tick;
    chk("rsp_early", 64'(rsp_valid), 64'd0);
    tick;
    chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << idx));
    chk("rsp_data", rsp_data, exp);
    rsp_ready[idx] = 1'b1;
    tick;
    rsp_ready[idx] = 1'b0;
    chk("rsp_done", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) tick;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick;

    set_req(0, 32'd2, 32'd2);
    serve(0, 64'd4, 1'b0);
    chk("single_idle", 64'(busy), 64'd0);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    rsp_ready = '1;
    set_req(0, 32'd20, 32'd10);
    set_req(1, 32'd2132, 32'd3212);
    set_req(2, 32'd5322, 32'd5652);
    set_req(3, 32'd76842, 32'd28654);
    serve(0, 64'd200, 1'b0);
    serve(1, 64'd6847984, 1'b0);
    chk("gap1", 64'(last_wait), 64'd0);
    serve(2, 64'd30079944, 1'b0);
    chk("gap2", 64'(last_wait), 64'd0);
    serve(3, 64'd2201830668, 1'b0);
    chk("gap3", 64'(last_wait), 64'd0);
    rsp_ready = '0;

    set_req(0, 32'd3, 32'd5);
    set_req(2, 32'd7, 32'd11);
    serve(0, 64'd15, 1'b1);
    set_req(0, 32'd6, 32'd9);
    serve(2, 64'd77, 1'b1);
    set_req(2, 32'd100, 32'd100);
    serve(0, 64'd54, 1'b0);
    serve(2, 64'd10000, 1'b0);

    set_req(1, 32'd76843552, 32'd28625354);
    #1;
    chk("bp_grant", 64'(req_ready), 64'b0010);
    tick;
    req_valid[1] = 1'b0;
    set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (L) tick;
    held = 64'd2199673878617408;
    rsp_ready[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("bp_valid", 64'(rsp_valid), 64'b0010);
      chk("bp_data", rsp_data, held);
      chk("bp_no_grant", 64'(req_ready), 64'd0);
      chk("bp_mul_a", 64'(mul_a), 64'd76843552);
      tick;
    end
    rsp_ready[0] = 1'b0;
    rsp_ready[1] = 1'b1;
    tick;
    rsp_ready[1] = 1'b0;
    chk("bp_release", 64'(rsp_valid), 64'd0);
    serve(3, 64'hFFFF_FFFE_0000_0001, 1'b0);
    set_req(0, 32'd0, 32'hFFFF_FFFF);
    serve(0, 64'd0, 1'b0);

    set_req(2, 32'd5, 32'd5);
    #1;
    chk("rw_grant", 64'(req_ready), 64'b0100);
    tick;
    req_valid[2] = 1'b0;
    tick;
    req_valid[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_mul_a", 64'(mul_a), 64'd0);
    chk("rw_mul_b", 64'(mul_b), 64'd0);
    chk("rw_rsp_data", rsp_data, 64'd0);
    chk("rw_req_ready", 64'(req_ready), 64'd0);
    tick;
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      chk("rw_no_rsp", 64'(rsp_valid), 64'd0);
      tick;
    end
    set_req(3, 32'd0, 32'd0);
    set_req(0, 32'd4, 32'd4);
    serve(0, 64'd16, 1'b0);
    serve(3, 64'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
